// File: rtl/xoodyak_ise_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_ise_issue_if
// Brief    : Core-side instruction/result handshake bundle for the Xoodyak
//            ISE issue controller (master = core, slave = controller).
// Revision : 1.0
// ============================================================================
interface xoodyak_ise_issue_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [63:0]      in_rs1;
    logic [63:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_rd;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_rd, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, in_tag, flush, out_ready,
        output in_ready, out_valid, out_rd, out_tag, out_err
    );
endinterface
`default_nettype wire

// File: rtl/xoodyak_ise.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_ise_issue
// Brief    : Two-stage (E/W) issue controller for the roli/roliw/andn RV64
//            ISE datapath. Optional perf counters: XOODYAK_ISE_PERF_EN.
// Revision : 1.0
// ============================================================================
module xoodyak_ise_issue #(
    parameter int TAG_W = 5
) (
    input  logic                g_clk,
    input  logic                g_rst,
    xoodyak_ise_issue_if.slave  bus,
    output logic [63:0]         ise_rs1,
    output logic [63:0]         ise_rs2,
    output logic [4:0]          ise_imm,
    output logic                ise_op_roli,
    output logic                ise_op_roliw,
    output logic                ise_op_andn,
    input  logic [63:0]         ise_rd
`ifdef XOODYAK_ISE_PERF_EN
    ,
    output logic [31:0]         perf_ops,
    output logic [31:0]         perf_ill
`endif
);
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_ROLI     = 3'b000;
    localparam logic [2:0] F3_ROLIW    = 3'b001;
    localparam logic [2:0] F3_ANDN     = 3'b010;

    // decode
    logic [2:0]       dec_op;
    logic [4:0]       dec_imm;
    logic             dec_ill;

    // stage E
    logic             e_valid;
    logic [2:0]       e_op;
    logic             e_ill;
    logic [63:0]      e_rs1;
    logic [63:0]      e_rs2;
    logic [4:0]       e_imm;
    logic [TAG_W-1:0] e_tag;

    // stage W
    logic             w_valid;
    logic [63:0]      w_rd;
    logic [TAG_W-1:0] w_tag;
    logic             w_err;

    logic             w_free;
    logic             e_adv;
    logic             accept;
    logic             w_load;

    always_comb begin
        dec_op  = 3'b000;
        dec_imm = bus.in_instr[24:20];
        case (bus.in_instr[14:12])
            F3_ROLI:  dec_op = 3'b001;
            F3_ROLIW: dec_op = 3'b010;
            F3_ANDN: begin
                dec_op  = 3'b100;
                dec_imm = 5'd0;
            end
            default:  dec_op = 3'b000;
        endcase
        dec_ill = (bus.in_instr[6:0] != OPC_CUSTOM0) ||
                  (bus.in_instr[31:25] != 7'd0) ||
                  (dec_op == 3'b000);
    end

    assign w_free       = !w_valid || bus.out_ready;
    assign e_adv        = e_valid && w_free;
    assign bus.in_ready = !e_valid || w_free;
    // A flush cycle drops the incoming op and suppresses the E->W load.
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_load       = e_adv && !bus.flush;

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            e_valid <= 1'b0;
        end else if (bus.flush) begin
            e_valid <= 1'b0;
        end else if (accept) begin
            e_valid <= 1'b1;
        end else if (e_adv) begin
            e_valid <= 1'b0;
        end
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            e_op  <= 3'b000;
            e_ill <= 1'b0;
            e_rs1 <= 64'd0;
            e_rs2 <= 64'd0;
            e_imm <= 5'd0;
            e_tag <= '0;
        end else if (accept) begin
            e_op  <= dec_op;
            e_ill <= dec_ill;
            e_rs1 <= bus.in_rs1;
            e_rs2 <= bus.in_rs2;
            e_imm <= dec_imm;
            e_tag <= bus.in_tag;
        end
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            w_valid <= 1'b0;
        end else if (bus.flush) begin
            w_valid <= 1'b0;
        end else if (e_adv) begin
            w_valid <= 1'b1;
        end else if (bus.out_ready) begin
            w_valid <= 1'b0;
        end
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            w_rd  <= 64'd0;
            w_tag <= '0;
            w_err <= 1'b0;
        end else if (w_load) begin
            w_rd  <= e_ill ? 64'd0 : ise_rd;
            w_tag <= e_tag;
            w_err <= e_ill;
        end
    end

    assign ise_rs1      = e_rs1;
    assign ise_rs2      = e_rs2;
    assign ise_imm      = e_imm;
    assign ise_op_roli  = e_valid && e_op[0] && !e_ill;
    assign ise_op_roliw = e_valid && e_op[1] && !e_ill;
    assign ise_op_andn  = e_valid && e_op[2] && !e_ill;

    assign bus.out_valid = w_valid;
    assign bus.out_rd    = w_rd;
    assign bus.out_tag   = w_tag;
    assign bus.out_err   = w_err;

`ifdef XOODYAK_ISE_PERF_EN
    logic retire;
    assign retire = w_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            perf_ops <= 32'd0;
            perf_ill <= 32'd0;
        end else if (retire) begin
            if (w_err) begin
                perf_ill <= perf_ill + 32'd1;
            end else begin
                perf_ops <= perf_ops + 32'd1;
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_xoodyak_ise_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_xoodyak_ise_issue
// Brief    : Directed + random bench for xoodyak_ise_issue with a queue-based
//            reference model. Perf checks enabled by XOODYAK_ISE_PERF_EN.
// Revision : 1.0
// ============================================================================
module tb_xoodyak_ise_issue;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xoodyak_ise_issue_if #(.TAG_W(TAG_W)) bus ();

    logic [63:0] ise_rs1, ise_rs2, ise_rd;
    logic [4:0]  ise_imm;
    logic        ise_op_roli, ise_op_roliw, ise_op_andn;
`ifdef XOODYAK_ISE_PERF_EN
    logic [31:0] perf_ops, perf_ill;
`endif

    xoodyak_ise_issue #(.TAG_W(TAG_W)) dut (
        .g_clk        (clk),
        .g_rst        (rst),
        .bus          (bus),
        .ise_rs1      (ise_rs1),
        .ise_rs2      (ise_rs2),
        .ise_imm      (ise_imm),
        .ise_op_roli  (ise_op_roli),
        .ise_op_roliw (ise_op_roliw),
        .ise_op_andn  (ise_op_andn),
        .ise_rd       (ise_rd)
`ifdef XOODYAK_ISE_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_ill     (perf_ill)
`endif
    );

    // Stand-in datapath; produces junk when no op is selected so illegal
    // results must be zeroed by the controller.
    logic [31:0] dp_lo;
    always_comb begin
        dp_lo  = 32'd0;
        ise_rd = ise_rs1 ^ {ise_rs2[31:0], ise_rs2[63:32]} ^ 64'hA5A5_5A5A_C3C3_3C3C;
        if (ise_op_roli) begin
            ise_rd = (ise_rs1 << ise_imm) | (ise_rs1 >> (7'd64 - {2'b00, ise_imm}));
        end else if (ise_op_roliw) begin
            dp_lo  = (ise_rs1[31:0] << ise_imm) | (ise_rs1[31:0] >> (6'd32 - {1'b0, ise_imm}));
            ise_rd = {{32{dp_lo[31]}}, dp_lo};
        end else if (ise_op_andn) begin
            ise_rd = ise_rs1 & ~ise_rs2;
        end
    end

    typedef struct {
        logic [63:0]      rd;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [2:0]       op;
        logic [4:0]       imm;
        int               age;
    } item_t;

    item_t       q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_ops  = 32'd0;
    logic [31:0] m_ill  = 32'd0;
    logic        last_acc;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] imm,
                                       input logic [2:0] f3, input logic [6:0] opc);
        return {f7, imm, 5'd7, 5'd9, f3, 5'd3, opc};
    endfunction

    function automatic item_t ref_item(input logic [31:0] ins, input logic [63:0] a,
                                       input logic [63:0] b, input logic [TAG_W-1:0] tag);
        item_t        it;
        logic [127:0] t128;
        logic [63:0]  t64;
        int           sh;
        sh     = int'(ins[24:20]);
        it.tag = tag;
        it.age = 1;
        it.imm = ins[24:20];
        it.err = !(ins[6:0] == 7'h0B && ins[31:25] == 7'd0 && ins[14:12] <= 3'd2);
        it.op  = 3'd0;
        it.rd  = 64'd0;
        if (!it.err) begin
            case (ins[14:12])
                3'd0: begin
                    t128  = {a, a} << sh;
                    it.rd = t128[127:64];
                    it.op = 3'b001;
                end
                3'd1: begin
                    t64   = {a[31:0], a[31:0]} << sh;
                    it.rd = {{32{t64[63]}}, t64[63:32]};
                    it.op = 3'b010;
                end
                default: begin
                    it.rd  = a & ~b;
                    it.op  = 3'b100;
                    it.imm = 5'd0;
                end
            endcase
        end
        return it;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
    endtask

    task automatic tick();
        logic  hv, exp_rdy, pop;
        int    e;
        item_t nw;
        #2;
        hv      = q.size() > 0 && q[0].age >= 2;
        exp_rdy = !(q.size() == 2 && !bus.out_ready);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(hv));
        if (hv) begin
            chk("out_rd", bus.out_rd, q[0].rd);
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
            chk("out_err", 64'(bus.out_err), 64'(q[0].err));
        end
        e = hv ? 1 : 0;
        if (q.size() > e) begin
            chk("ise_op", 64'({ise_op_andn, ise_op_roliw, ise_op_roli}), 64'(q[e].op));
            if (q[e].op != 3'd0) chk("ise_imm", 64'(ise_imm), 64'(q[e].imm));
        end else begin
            chk("ise_op_idle", 64'({ise_op_andn, ise_op_roliw, ise_op_roli}), 64'd0);
        end
`ifdef XOODYAK_ISE_PERF_EN
        chk("perf_ops", 64'(perf_ops), 64'(m_ops));
        chk("perf_ill", 64'(perf_ill), 64'(m_ill));
`endif
        last_acc = bus.in_valid && exp_rdy && !bus.flush;
        pop      = hv && bus.out_ready && !bus.flush;
        nw       = ref_item(bus.in_instr, bus.in_rs1, bus.in_rs2, bus.in_tag);
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pop) begin
                if (q[0].err) m_ill++; else m_ops++;
                void'(q.pop_front());
            end
            foreach (q[i]) if (q[i].age < 2) q[i].age++;
            if (last_acc) q.push_back(nw);
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 3) return mk(7'd0, 5'($urandom), 3'd0, 7'h0B);
        if (k < 6) return mk(7'd0, 5'($urandom), 3'd1, 7'h0B);
        if (k < 8) return mk(7'd0, 5'($urandom), 3'd2, 7'h0B);
        if (k == 8) return mk(7'd0, 5'($urandom), 3'($urandom_range(3, 7)), 7'h0B);
        return mk(7'($urandom_range(1, 127)), 5'($urandom), 3'($urandom_range(0, 2)), 7'h0B);
    endfunction

    initial begin
        int k;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_rd", bus.out_rd, 64'd0);
        chk("rst_ise_rs1", ise_rs1, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // latency: roli imm=8
        bus.out_ready = 1'b1;
        drive(1'b1, mk(7'd0, 5'd8, 3'd0, 7'h0B), 64'h0123456789ABCDEF, 64'd0, 5'd3);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        repeat (3) tick();

        // andn with nonzero immediate field
        drive(1'b1, mk(7'd0, 5'h1F, 3'd2, 7'h0B), 64'hFF00, 64'h0F00, 5'd4);
        tick();
        // illegal funct3 and illegal funct7
        drive(1'b1, mk(7'd0, 5'd5, 3'd3, 7'h0B), 64'h1234, 64'h5678, 5'd5);
        tick();
        drive(1'b1, mk(7'd1, 5'd5, 3'd0, 7'h0B), 64'h1234, 64'h5678, 5'd6);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        repeat (3) tick();

        // streaming under back-pressure
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (c >= 5) bus.out_ready = 1'b1;
            if (k < 4) drive(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, 5'(10 + k));
            else drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
            tick();
            if (last_acc) k++;
        end
        chk("stream_all_accepted", 64'(k), 64'd4);

        // flush with both stages full
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, 5'(20 + c));
            tick();
        end
        bus.flush = 1'b1;
        drive(1'b1, rand_instr(), 64'd1, 64'd2, 5'd30);
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, mk(7'd0, 5'd1, 3'd1, 7'h0B), 64'h8000_0000_4000_0001, 64'd0, 5'h1D);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        repeat (3) tick();

        // asynchronous reset with two ops in flight
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, 5'(c + 1));
            tick();
        end
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_rd", bus.out_rd, 64'd0);
        chk("arst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("arst_out_err", 64'(bus.out_err), 64'd0);
        chk("arst_ise_op", 64'({ise_op_andn, ise_op_roliw, ise_op_roli}), 64'd0);
        chk("arst_ise_ops", {ise_rs1 | ise_rs2}, 64'd0);
        chk("arst_ise_imm", 64'(ise_imm), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        m_ops = 32'd0;
        m_ill = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive(1'b1, mk(7'd0, 5'd17, 3'd0, 7'h0B), 64'hDEAD_BEEF_0000_0001, 64'd0, 5'd9);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        repeat (3) tick();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
                  {$urandom, $urandom}, 5'($urandom));
            tick();
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'd0, 64'd0, 64'd0, '0);
        repeat (4) tick();
        chk("drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/xoodyak_ise_issue.md
Name: xoodyak_ise_issue

Overview:
- Issue-side controller for the Xoodyak RV64 ISE datapath (roli / roliw / andn).
- Accepts a custom-0 instruction word plus operands from the core with a valid/ready handshake.
- Decodes the word, registers operands, and drives the external combinational ISE datapath.
- Captures its result and returns rd with tag and error status through a 2-stage stall-able pipeline.

Parameters:
- TAG_W, 5, width of destination-register tag passed through unchanged.

Ports:
- g_clk  input  1  clock
- g_rst  input  1  asynchronous active-high reset
- in_valid  input  1  instruction presented
- in_ready  output  1  controller accepts this cycle
- in_instr  input  32  instruction word
- in_rs1  input  64  operand 1
- in_rs2  input  64  operand 2
- in_tag  input  TAG_W  destination tag
- flush  input  1  kill all in-flight ops
- ise_rs1  output  64  datapath operand 1 (stage E register)
- ise_rs2  output  64  datapath operand 2 (stage E register)
- ise_imm  output  5  datapath immediate
- ise_op_roli  output  1  datapath select
- ise_op_roliw  output  1  datapath select
- ise_op_andn  output  1  datapath select
- ise_rd  input  64  datapath result, combinational from ise_* outputs
- out_valid  output  1  result available
- out_ready  input  1  core consumes result
- out_rd  output  64  result
- out_tag  output  TAG_W  tag
- out_err  output  1  illegal encoding

Behaviour:
- Decode rules:
  - Legal only if instr[6:0]=7'b0001011 and instr[31:25]=0.
  - funct3 = instr[14:12]: 000 roli, 001 roliw, 010 andn; any other value is illegal.
  - imm = instr[24:20] for roli/roliw; forced to 0 for andn.
- Stage E registers: e_valid, decoded one-hot op, illegal flag, rs1, rs2, imm, tag.
  - ise_op_* = e_valid & op & !illegal; at most one is high.
  - ise_rs1/ise_rs2/ise_imm are driven straight from the E registers.
- Stage W registers: w_valid, rd, tag, err.
  - On E to W transfer: w_rd = ise_rd, or 0 if illegal; w_err = illegal.
- Handshake:
  - w_free = !w_valid | out_ready.
  - e_adv = e_valid & w_free.
  - in_ready = !e_valid | w_free.
  - Accept on in_valid & in_ready; out fields come from the W registers.
- Latency: accept at cycle N gives out_valid at N+2 with no stall. Sustained throughput is 1 op/cycle while out_ready=1.
- Back-pressure:
  - out_valid, out_rd, out_tag and out_err are held stable until out_ready.
  - in_ready drops only when both stages are full and out_ready=0.
  - Pipeline holds at most 2 ops.
- Simultaneous events (same cycle):
  - Accept + E advance + W drain all occur together; no bubble.
  - in_valid is ignored while in_ready=0 (core must hold).
- Flush:
  - Clears e_valid and w_valid at the next edge; no output handshake completes that cycle.
  - Any in_valid in the flush cycle is dropped.
  - in_ready=1 the following cycle.
- Reset (asynchronous assert):
  - e_valid, w_valid, out_valid, out_err = 0; out_rd, out_tag = 0.
  - All ise_op_* = 0; ise_rs1, ise_rs2, ise_imm = 0.
  - Reset mid-operation discards in-flight ops.
- Data registers update only on their stage load enable, which keeps switching down.

Optional Feature:
- Macro: XOODYAK_ISE_PERF_EN.
- When defined, adds outputs perf_ops[31:0] and perf_ill[31:0].
  - perf_ops counts legal results completing out_valid&out_ready.
  - perf_ill counts illegal results completing the same handshake.
  - Both wrap modulo 2^32, are cleared by reset, and are unaffected by flush of unretired ops.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Pipeline latency: roli imm=8, rs1=64'h0123456789ABCDEF, out_ready=1 -> out_valid 2 cycles after accept; ise_op_roli=1 and ise_imm=8 one cycle after accept; out_rd = ise_rd, out_err=0, tag echoed.
- Decode/immediate: andn with rs1=64'hFF00, rs2=64'h0F00, instr[24:20]=5'h1F -> ise_op_andn=1, ise_imm=0, out_rd = ise_rd.
- Illegal encodings: funct3=011, or funct7=1 -> out_err=1, out_rd=0, no ise_op_* asserted; perf_ill increments if enabled.
- Back-to-back streaming: 4 ops with out_ready held 0 -> in_ready=0 after 2 accepts. Release out_ready -> results emerge in order with stable fields, 1 per cycle; no loss or duplication.
- Flush with both stages full: flush high -> next cycle out_valid=0 and in_ready=1; the next accepted op returns its own tag.
- Reset mid-op: assert g_rst asynchronously mid-clock with 2 ops in flight -> all outputs 0 immediately. After release, the first accepted op completes normally.
